mem_byte_fetcher: RTL and testbench

- Upstream stage of the MAC-FIFO datapath.
- On `start`, reads NUM_WORDS consecutive 64-bit words from on-chip memory over an Avalon-MM read master.
- Unpacks each word into 8 bytes and streams them, MSB byte first, over a valid/ready byte interface.
- The FIFO fill controller consumes this stream to load the A FIFOs (words 0..7) and the B FIFO (word 8).

---
 rtl/mem_byte_fetcher.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_byte_fetcher.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_fetcher
// Purpose  : Reads NUM_WORDS consecutive 64-bit words over an Avalon-MM read
//            master and streams each word out as 8 bytes, MSB byte first,
//            on a valid/ready byte interface. Upstream of the MAC-FIFO fill.
// Ports    : clk, rst (async, active high)
//            start              - run request, sampled in IDLE only
//            busy / done        - run in progress / one-cycle completion pulse
//            avm_address/read   - Avalon word address and read request
//            avm_readdata/valid - read return data and its valid strobe
//            avm_waitrequest    - slave stall
//            byte_out/valid     - byte stream, consumed when byte_ready is high
//            byte_idx/word_idx  - position of byte_out within the run
//            last_byte          - final byte of the run
// Options  : MEM_FETCH_PREFETCH_EN - second word buffer; the next word is read
//            while the current one streams, removing the per-word gap.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_fetcher #(
   parameter int                ADDR_W    = 32,
   parameter int                NUM_WORDS = 9,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic [63:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic [2:0]        byte_idx,
   output logic [7:0]        word_idx,
   output logic              last_byte
);

   localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_DATA = 3'd2,
      S_STREAM    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [63:0]       word_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        byte_idx_q;
   logic [7:0]        word_idx_q;

   logic hs;          // byte accepted this cycle
   logic byte7_hs;    // final byte of a word accepted
   logic last_word;
   logic next_word;   // word boundary with more words to follow
   logic take_rdata;  // read data that belongs to us is arriving

   assign hs        = byte_valid & byte_ready;
   assign byte7_hs  = hs & (byte_idx_q == 3'd7);
   assign last_word = (word_idx_q == LAST_WORD);
   assign next_word = byte7_hs & ~last_word;

`ifdef MEM_FETCH_PREFETCH_EN
   localparam logic [8:0] NUM_READS = 9'(NUM_WORDS);

   logic [63:0] spare_q;
   logic        spare_full;
   logic        outstanding;   // a read was accepted and its data is not back
   logic        pf_pending;    // prefetch read requested, not yet accepted
   logic [8:0]  rd_cnt;        // reads accepted so far in this run
   logic        rd_acc;
   logic        next_ready;    // next word available at the byte-7 handshake
   logic        enter_word;    // byte 0 of a new word appears next cycle

   assign take_rdata = avm_readdatavalid & outstanding;
   assign rd_acc     = avm_read & ~avm_waitrequest;
   assign next_ready = spare_full | take_rdata;
   assign enter_word = ((state == S_WAIT_DATA) & take_rdata) |
                       ((state == S_STREAM) & next_word & next_ready);
`else
   // Only one read is ever in flight and data is only taken in WAIT_DATA.
   assign take_rdata = avm_readdatavalid;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      byte_valid = 1'b0;
      avm_read   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               state_nxt = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (take_rdata) begin
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            byte_valid = 1'b1;
            if (byte7_hs) begin
               if (last_word) begin
                  state_nxt = S_DONE;
`ifdef MEM_FETCH_PREFETCH_EN
               end else if (!next_ready) begin
                  state_nxt = S_WAIT_DATA;
`else
               end else begin
                  state_nxt = S_REQ;
`endif
               end
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
`ifdef MEM_FETCH_PREFETCH_EN
      // Prefetch reads are issued from STREAM or WAIT_DATA.
      avm_read = avm_read | pf_pending;
`endif
   end

   // ------------------------------------------------------------------------
   // Datapath: address, word buffer(s), byte/word counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= '0;
         addr_q     <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
`ifdef MEM_FETCH_PREFETCH_EN
         spare_q     <= '0;
         spare_full  <= 1'b0;
         outstanding <= 1'b0;
         pf_pending  <= 1'b0;
         rd_cnt      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q     <= BASE_ADDR;
                  word_idx_q <= '0;
                  byte_idx_q <= '0;
`ifdef MEM_FETCH_PREFETCH_EN
                  rd_cnt      <= '0;
                  spare_full  <= 1'b0;
                  outstanding <= 1'b0;
                  pf_pending  <= 1'b0;
`endif
               end
            end
            S_WAIT_DATA: begin
               if (take_rdata) begin
                  word_q     <= avm_readdata;
                  byte_idx_q <= '0;
               end
            end
            S_STREAM: begin
               if (hs) begin
                  // Wraps 7 -> 0 at the word boundary.
                  byte_idx_q <= byte_idx_q + 3'd1;
               end
               if (next_word) begin
                  word_idx_q <= word_idx_q + 8'd1;
`ifdef MEM_FETCH_PREFETCH_EN
                  if (spare_full) begin
                     word_q <= spare_q;
                  end else if (take_rdata) begin
                     word_q <= avm_readdata;
                  end
`else
                  addr_q <= addr_q + ADDR_W'(1);
`endif
               end
            end
            default: begin
            end
         endcase

`ifdef MEM_FETCH_PREFETCH_EN
         // The address always points at the next read to issue.
         if (rd_acc) begin
            addr_q <= addr_q + ADDR_W'(1);
            rd_cnt <= rd_cnt + 9'd1;
         end

         if (rd_acc) begin
            outstanding <= 1'b1;
         end else if (take_rdata) begin
            outstanding <= 1'b0;
         end

         // Prefetch data lands in the spare buffer unless it is consumed
         // directly at the word boundary in the same cycle.
         if ((state == S_STREAM) && take_rdata && !next_word) begin
            spare_q    <= avm_readdata;
            spare_full <= 1'b1;
         end else if ((state == S_STREAM) && next_word && spare_full) begin
            spare_full <= 1'b0;
         end

         if (enter_word) begin
            pf_pending <= (rd_cnt != NUM_READS);
         end else if (rd_acc) begin
            pf_pending <= 1'b0;
         end
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Stream outputs: byte 0 is bits [63:56]
   // ------------------------------------------------------------------------
   assign avm_address = addr_q;
   assign byte_idx    = byte_idx_q;
   assign word_idx    = word_idx_q;
   assign byte_out    = word_q[{~byte_idx_q, 3'b000} +: 8];
   assign last_byte   = byte_valid & last_word & (byte_idx_q == 3'd7);

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_byte_fetcher
// Purpose  : Self-checking bench for mem_byte_fetcher with a zero-wait,
//            two-cycle-return Avalon memory model and a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_byte_fetcher;

   localparam int                ADDR_W    = 32;
   localparam int                NUM_WORDS = 9;
   localparam logic [ADDR_W-1:0] BASE      = '0;
`ifdef MEM_FETCH_PREFETCH_EN
   localparam int RUN_CYC = 76;    // 4 startup + 72 back-to-back bytes
`else
   localparam int RUN_CYC = 100;   // 4 startup + 8 words * 11 + 8 stream
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              busy, done;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic [63:0]       avm_readdata;
   logic              avm_readdatavalid;
   logic              avm_waitrequest = 1'b0;
   logic [7:0]        byte_out;
   logic              byte_valid;
   logic              byte_ready = 1'b0;
   logic [2:0]        byte_idx;
   logic [7:0]        word_idx;
   logic              last_byte;

   logic              inj_rdv = 1'b0;
   logic              p_v = 1'b0;
   logic [3:0]        p_a = '0;
   logic              slv_rdv = 1'b0;
   logic [63:0]       slv_rdata = '0;
   logic [63:0]       mem [0:15];

   typedef struct packed {
      logic [7:0] b;
      logic [2:0] bi;
      logic [7:0] wi;
      logic       lb;
   } exp_t;

   exp_t              sbq[$];
   logic [ADDR_W-1:0] acc_log[$];
   int                errors = 0;
   int                checks = 0;

   always #5 clk = ~clk;

   mem_byte_fetcher #(
      .ADDR_W    (ADDR_W),
      .NUM_WORDS (NUM_WORDS),
      .BASE_ADDR (BASE)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest),
      .byte_out          (byte_out),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready),
      .byte_idx          (byte_idx),
      .word_idx          (word_idx),
      .last_byte         (last_byte)
   );

   // Memory: accepted read at edge N returns data during the cycle after N+1.
   always @(posedge clk) begin
      p_v       <= avm_read && !avm_waitrequest;
      p_a       <= avm_address[3:0];
      slv_rdv   <= p_v;
      slv_rdata <= mem[p_a];
   end

   assign avm_readdatavalid = slv_rdv | inj_rdv;
   assign avm_readdata      = inj_rdv ? 64'hDEAD_BEEF_DEAD_BEEF : slv_rdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: plain run, 1: byte_ready stall on byte 03,
   // 2: stray start / stray readdatavalid / start in DONE, 3: reset mid-run
   task automatic run(input int mode, input int ws,
                      output int done_cyc, output int first_cyc, output int rd0_cyc);
      int   cyc;
      int   stall;
      bit   stalled;
      int   ws_used;
      exp_t e;
      exp_t got;
      sbq.delete();
      acc_log.delete();
      for (int w = 0; w < NUM_WORDS; w++) begin
         for (int b = 0; b < 8; b++) begin
            e.b  = mem[w][63-8*b -: 8];
            e.bi = 3'(b);
            e.wi = 8'(w);
            e.lb = (w == NUM_WORDS - 1) && (b == 7);
            sbq.push_back(e);
         end
      end
      done_cyc  = -1;
      first_cyc = -1;
      rd0_cyc   = 0;
      stall     = 0;
      stalled   = 0;
      ws_used   = 0;
      byte_ready = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (cyc < 3000 && done_cyc < 0) begin
         start   = (mode == 2 && cyc == 30);
         inj_rdv = (mode == 2 && byte_valid && word_idx == 8'd1 && byte_idx == 3'd5);
         avm_waitrequest = avm_read && (ws_used < ws);
         if (avm_waitrequest) ws_used++;
         if (avm_read && !avm_waitrequest) acc_log.push_back(avm_address);
         if (avm_read && avm_address == BASE) rd0_cyc++;
         if (byte_valid && first_cyc < 0) first_cyc = cyc;
         byte_ready = 1'b1;
         if (mode == 1 && !stalled && byte_valid && word_idx == 8'd0 && byte_idx == 3'd2) begin
            stalled = 1;
            stall   = 5;
         end
         if (stall > 0) begin
            byte_ready = 1'b0;
            stall--;
            checks++;
            if ({byte_valid, byte_idx, byte_out} !== {1'b1, 3'd2, 8'h03}) begin
               errors++;
               $display("FAIL stall_hold valid/idx/byte got=%b/%0d/%h want=1/2/03",
                        byte_valid, byte_idx, byte_out);
            end
         end
         if (mode == 3 && byte_valid && word_idx == 8'd4 && byte_idx == 3'd5) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({busy, done, avm_read, byte_valid, last_byte} !== 5'b0 ||
                avm_address !== '0 || byte_out !== 8'h00 ||
                byte_idx !== 3'd0 || word_idx !== 8'd0) begin
               errors++;
               $display("FAIL async_reset busy=%b done=%b rd=%b bv=%b lb=%b addr=%h byte=%h bi=%0d wi=%0d want all 0",
                        busy, done, avm_read, byte_valid, last_byte, avm_address,
                        byte_out, byte_idx, word_idx);
            end
            tick();
            rst = 1'b0;
            break;
         end
         if (byte_valid && byte_ready) begin
            checks++;
            got = {byte_out, byte_idx, word_idx, last_byte};
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL byte_stream extra byte got=%h", got);
            end else begin
               e = sbq.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL byte_stream byte/bi/wi/last got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b",
                           got.b, got.bi, got.wi, got.lb, e.b, e.bi, e.wi, e.lb);
               end
            end
         end
         if (done) begin
            done_cyc = cyc;
            if (mode == 2) start = 1'b1;
         end
         tick();
         cyc++;
      end
      start           = 1'b0;
      inj_rdv         = 1'b0;
      avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, avm_read, byte_valid, last_byte} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl busy/done/rd/bv/lb got=%b want=00000",
                  {busy, done, avm_read, byte_valid, last_byte});
      end
      checks++;
      if (avm_address !== '0 || byte_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_data addr=%h byte=%h want 0/0", avm_address, byte_out);
      end
      checks++;
      if (byte_idx !== 3'd0 || word_idx !== 8'd0) begin
         errors++;
         $display("FAIL reset_idx bi=%0d wi=%0d want 0/0", byte_idx, word_idx);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stream_latency();
      int  dc, fc, r0;
      bit  ok;
      run(0, 0, dc, fc, r0);
      checks++;
      if (fc !== 4) begin
         errors++;
         $display("FAIL first_valid_cycle got=%0d want=4", fc);
      end
      checks++;
      if (dc !== RUN_CYC) begin
         errors++;
         $display("FAIL done_cycle got=%0d want=%0d", dc, RUN_CYC);
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL bytes_missing got=%0d left want=0", sbq.size());
      end
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL done_single_pulse done/busy got=%b%b want=00", done, busy);
      end
      ok = (acc_log.size() == NUM_WORDS);
      for (int i = 0; i < acc_log.size(); i++) begin
         if (acc_log[i] !== BASE + ADDR_W'(i)) ok = 0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL read_addresses got count=%0d want %0d in order from %h",
                  acc_log.size(), NUM_WORDS, BASE);
      end
   endtask

   task automatic test_waitrequest_stall();
      int dc, fc, r0;
      run(1, 3, dc, fc, r0);
      checks++;
      if (r0 !== 4) begin
         errors++;
         $display("FAIL wait_addr0_cycles got=%0d want=4", r0);
      end
      checks++;
      if (acc_log.size() != NUM_WORDS || acc_log[0] !== BASE) begin
         errors++;
         $display("FAIL wait_accepts got=%0d want=%0d", acc_log.size(), NUM_WORDS);
      end
      checks++;
      if (fc !== 7 || dc !== RUN_CYC + 8) begin
         errors++;
         $display("FAIL wait_timing first/done got=%0d/%0d want=7/%0d", fc, dc, RUN_CYC + 8);
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL wait_bytes_missing got=%0d want=0", sbq.size());
      end
   endtask

   task automatic test_start_ignored();
      int dc, fc, r0;
      run(2, 0, dc, fc, r0);
      checks++;
      if (dc !== RUN_CYC || sbq.size() != 0) begin
         errors++;
         $display("FAIL busy_start done_cycle/left got=%0d/%0d want=%0d/0", dc, sbq.size(), RUN_CYC);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL done_exit_busy got=%b want=0", busy);
      end
      tick();
      checks++;
      if ({busy, avm_read} !== 2'b00) begin
         errors++;
         $display("FAIL start_in_done_ignored busy/rd got=%b%b want=00", busy, avm_read);
      end
   endtask

   task automatic test_reset_mid_run();
      int dc, fc, r0;
      run(3, 0, dc, fc, r0);
      tick();
      checks++;
      if (dc !== -1 || {busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_no_done done_cyc=%0d busy/done=%b%b want=-1/00", dc, busy, done);
      end
   endtask

   task automatic test_restart();
      int dc, fc, r0;
      run(0, 0, dc, fc, r0);
      checks++;
      if (acc_log.size() == 0 || acc_log[0] !== BASE) begin
         errors++;
         $display("FAIL restart_addr got count=%0d want first addr %h", acc_log.size(), BASE);
      end
      checks++;
      if (dc !== RUN_CYC || sbq.size() != 0) begin
         errors++;
         $display("FAIL restart_run done_cycle/left got=%0d/%0d want=%0d/0", dc, sbq.size(), RUN_CYC);
      end
   endtask

   initial begin
      mem[0] = 64'h0102030405060708;
      for (int k = 1; k < 16; k++) mem[k] = {8{8'(k + 1)}};
      test_reset();
      test_stream_latency();
      test_waitrequest_stall();
      test_start_ignored();
      test_reset_mid_run();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
